// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART with shared baud divisor.
// Independent TX/RX state machines; optional RX FIFO via UART_RX_FIFO_EN.
//
// Ports:
//   clk, reset   clock, async active-high reset
//   sel          peripheral-space qualifier
//   addr         byte address (exact match to ADDR_TXD/RXD/CON)
//   rd, wr       read / write strobes
//   wdata        write data
//   rdata        combinational read data (0 when not reading a register)
//   rx, tx       serial in (async) / serial out
//   rx_irq       level receive interrupt (rx_valid & rx_ie)
//
// Macro UART_RX_FIFO_EN: RXD becomes a 4-entry FIFO, CON[9:8] = occupancy-1.
module uart_mmio #(
    parameter int unsigned BAUD_DIV = 10417,
    parameter logic [31:0] ADDR_TXD = 32'h4000_0018,
    parameter logic [31:0] ADDR_RXD = 32'h4000_001C,
    parameter logic [31:0] ADDR_CON = 32'h4000_0020
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [31:0] addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        rx,
    output logic        tx,
    output logic        rx_irq
);

    localparam logic [15:0] BAUD_RLD = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_RLD = 16'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic acc_txd, acc_rxd, acc_con;
    logic wr_txd, wr_con, rd_rxd, rd_con;

    assign acc_txd = sel && (addr == ADDR_TXD);
    assign acc_rxd = sel && (addr == ADDR_RXD);
    assign acc_con = sel && (addr == ADDR_CON);
    assign wr_txd  = acc_txd && wr;
    assign wr_con  = acc_con && wr;
    assign rd_rxd  = acc_rxd && rd;
    assign rd_con  = acc_con && rd;

    logic unused;
    assign unused = ^{wdata[31:8], wdata[0]};

    // ---------------- TX ----------------
    state_t      tx_state, tx_next;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_idx;
    logic [7:0]  tx_shr;
    logic        tx_tick;
    logic        tx_busy;
    logic        tx_done_set;

    assign tx_tick = (tx_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) tx_state <= S_IDLE;
        else       tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        unique case (tx_state)
            S_IDLE:  if (wr_txd) tx_next = S_START;
            S_START: if (tx_tick) tx_next = S_DATA;
            S_DATA:  if (tx_tick && tx_idx == 3'd7) tx_next = S_STOP;
            S_STOP:  if (tx_tick) tx_next = S_IDLE;
            default: tx_next = S_IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        unique case (tx_state)
            S_START: tx = 1'b0;
            S_DATA:  tx = tx_shr[tx_idx];
            default: tx = 1'b1;
        endcase
    end

    assign tx_busy     = (tx_state != S_IDLE);
    assign tx_done_set = (tx_state == S_STOP) && tx_tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_cnt <= '0;
            tx_idx <= '0;
            tx_shr <= '0;
        end else if (tx_state == S_IDLE) begin
            if (wr_txd) begin
                tx_shr <= wdata[7:0];
                tx_cnt <= BAUD_RLD;
                tx_idx <= '0;
            end
        end else if (tx_tick) begin
            tx_cnt <= BAUD_RLD;
            if (tx_state == S_DATA) tx_idx <= tx_idx + 3'd1;
        end else begin
            tx_cnt <= tx_cnt - 16'd1;
        end
    end

    // ---------------- RX ----------------
    logic        rx_m, rx_s;
    state_t      rx_state, rx_next;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_idx;
    logic [7:0]  rx_shr;
    logic        rx_tick;
    logic        rx_done;
    logic        rx_ferr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    assign rx_tick = (rx_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rx_state <= S_IDLE;
        else       rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        unique case (rx_state)
            S_IDLE:  if (!rx_s) rx_next = S_START;
            S_START: if (rx_tick) rx_next = rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (rx_tick && rx_idx == 3'd7) rx_next = S_STOP;
            S_STOP:  if (rx_tick) rx_next = S_IDLE;
            default: rx_next = S_IDLE;
        endcase
    end

    always_comb begin
        rx_done = 1'b0;
        rx_ferr = 1'b0;
        if (rx_state == S_STOP && rx_tick) begin
            rx_done = rx_s;
            rx_ferr = !rx_s;
        end
    end

    // Idle keeps the half-bit count preloaded so START samples mid-bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_cnt <= '0;
            rx_idx <= '0;
            rx_shr <= '0;
        end else if (rx_state == S_IDLE) begin
            rx_cnt <= HALF_RLD;
            rx_idx <= '0;
        end else if (rx_tick) begin
            rx_cnt <= BAUD_RLD;
            if (rx_state == S_DATA) begin
                rx_shr <= {rx_s, rx_shr[7:1]};
                rx_idx <= rx_idx + 3'd1;
            end
        end else begin
            rx_cnt <= rx_cnt - 16'd1;
        end
    end

    // ---------------- RX data store ----------------
    logic       rx_valid;
    logic [7:0] rxd_out;
    logic [1:0] occ;
    logic       ovr_set;

`ifdef UART_RX_FIFO_EN
    logic [7:0] fifo [4];
    logic [1:0] wp, rp;
    logic [2:0] cnt;
    logic       full, empty, push, pop;

    assign full    = (cnt == 3'd4);
    assign empty   = (cnt == 3'd0);
    assign pop     = rd_rxd && !empty;
    assign push    = rx_done && (!full || pop);
    assign ovr_set = rx_done && full && !pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) fifo[i] <= '0;
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) begin
                fifo[wp] <= rx_shr;
                wp       <= wp + 2'd1;
            end
            if (pop) rp <= rp + 2'd1;
            cnt <= cnt + {2'b0, push} - {2'b0, pop};
        end
    end

    assign rx_valid = !empty;
    assign rxd_out  = fifo[rp];
    assign occ      = empty ? 2'b00 : 2'(cnt - 3'd1);
`else
    logic [7:0] rxd_q;
    logic       rx_valid_q;

    // A completing byte beats a same-cycle RXD read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxd_q      <= '0;
            rx_valid_q <= 1'b0;
        end else if (rx_done) begin
            rxd_q      <= rx_shr;
            rx_valid_q <= 1'b1;
        end else if (rd_rxd) begin
            rx_valid_q <= 1'b0;
        end
    end

    assign rx_valid = rx_valid_q;
    assign rxd_out  = rxd_q;
    assign occ      = 2'b00;
    assign ovr_set  = rx_done && rx_valid_q && !rd_rxd;
`endif

    // ---------------- CON ----------------
    logic rx_ie, tx_done, rx_ovr, frame_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_ie     <= 1'b0;
            tx_done   <= 1'b0;
            rx_ovr    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (wr_con) rx_ie <= wdata[1];
            if (tx_done_set) tx_done <= 1'b1;
            else if (rd_con) tx_done <= 1'b0;
            if (ovr_set)     rx_ovr <= 1'b1;
            else if (rd_con) rx_ovr <= 1'b0;
            if (rx_ferr)     frame_err <= 1'b1;
            else if (rd_con) frame_err <= 1'b0;
        end
    end

    assign rx_irq = rx_valid && rx_ie;

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            rd_rxd:  rdata = {24'b0, rxd_out};
            rd_con:  rdata = {22'b0, occ, 1'b0, frame_err, rx_ovr,
                              tx_done, rx_valid, tx_busy, rx_ie, 1'b0};
            default: rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: scoreboard bench for uart_mmio at 16 cycles per bit.
// Register accesses and TX frames are checked by one monitor process.
module tb_uart_mmio;

    localparam int BD = 16;
    localparam logic [31:0] TXD = 32'h4000_0018;
    localparam logic [31:0] RXD = 32'h4000_001C;
    localparam logic [31:0] CON = 32'h4000_0020;
    localparam logic [31:0] BAD = 32'h4000_0024;
`ifdef UART_RX_FIFO_EN
    localparam logic [31:0] RXD_KEEP = 32'h01;
`else
    localparam logic [31:0] RXD_KEEP = 32'h22;
`endif

    logic        clk = 1'b0;
    logic        reset, sel, rd, wr, rx;
    logic [31:0] addr, wdata, rdata;
    logic        tx, rx_irq;

    uart_mmio #(.BAUD_DIV(BD)) dut (
        .clk    (clk),
        .reset  (reset),
        .sel    (sel),
        .addr   (addr),
        .rd     (rd),
        .wr     (wr),
        .wdata  (wdata),
        .rdata  (rdata),
        .rx     (rx),
        .tx     (tx),
        .rx_irq (rx_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] d;
        logic        irq;
    } exp_t;

    exp_t       rdq[$];
    logic [7:0] txq[$];
    int         n_cmp = 0;
    int         n_fail = 0;
    logic       probe = 1'b0;
    logic       fin = 1'b0;
    logic       fin_done = 1'b0;

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endfunction

    // Monitor: register accesses, reset probes, TX frame decoder.
    initial begin : monitor
        exp_t       e;
        logic [7:0] tb;
        int         tx_t;
        logic       tx_prev, tx_ab;
        logic [9:0] tx_fr;
        tx_t    = 0;
        tx_prev = 1'b1;
        tx_ab   = 1'b0;
        tx_fr   = '0;
        forever begin
            @(negedge clk);
            if (probe) begin
                chk("probe_tx", {31'b0, tx}, 32'd1);
                chk("probe_irq", {31'b0, rx_irq}, 32'd0);
            end
            if (sel) begin
                if (rdq.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexp_access: got addr 0x%08h want none", addr);
                end else begin
                    e = rdq.pop_front();
                    chk(e.nm, rdata, e.d);
                    chk({e.nm, "_irq"}, {31'b0, rx_irq}, {31'b0, e.irq});
                end
            end
            if (tx_t == 0) begin
                if (!reset && tx_prev && !tx) begin
                    tx_t  = 1;
                    tx_ab = 1'b0;
                end
            end else begin
                tx_t++;
                tx_ab = tx_ab | reset;
                if (tx_t == 9) begin
                    tx_fr[0] = tx;
                end else if (tx_t >= 25 && tx_t <= 137 && (tx_t - 25) % 16 == 0) begin
                    tx_fr[1 + (tx_t - 25) / 16] = tx;
                end else if (tx_t == 153) begin
                    tx_fr[9] = tx;
                    tx_t = 0;
                    if (!tx_ab) begin
                        if (txq.size() == 0) begin
                            n_cmp++;
                            n_fail++;
                            $display("FAIL unexp_frame: got 0x%03h want none", tx_fr);
                        end else begin
                            tb = txq.pop_front();
                            chk("tx_frame", {22'b0, tx_fr}, {22'b0, 1'b1, tb, 1'b0});
                        end
                    end
                end
            end
            tx_prev = tx;
            if (fin && !fin_done) begin
                chk("rdq_left", 32'(rdq.size()), 32'd0);
                chk("txq_left", 32'(txq.size()), 32'd0);
                fin_done = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic acc(input logic [31:0] a, input logic r, input logic w,
                       input logic [31:0] wd, input logic [31:0] d,
                       input logic irq, input string nm);
        exp_t e;
        e.nm  = nm;
        e.d   = d;
        e.irq = irq;
        rdq.push_back(e);
        sel   = 1'b1;
        addr  = a;
        rd    = r;
        wr    = w;
        wdata = wd;
        tick();
        sel   = 1'b0;
        rd    = 1'b0;
        wr    = 1'b0;
        addr  = '0;
        wdata = '0;
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [31:0] d,
                          input logic irq, input string nm);
        acc(a, 1'b1, 1'b0, 32'd0, d, irq, nm);
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] wd,
                          input string nm);
        acc(a, 1'b0, 1'b1, wd, 32'd0, 1'b0, nm);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (BD) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BD) tick();
        end
        rx = stop;
        repeat (BD) tick();
        rx = 1'b1;
    endtask

    initial begin : stim
        reset = 1'b1;
        sel   = 1'b0;
        rd    = 1'b0;
        wr    = 1'b0;
        addr  = '0;
        wdata = '0;
        rx    = 1'b1;
        probe = 1'b1;
        repeat (3) tick();
        probe = 1'b0;
        reset = 1'b0;
        repeat (2) tick();

        rd_chk(CON, 32'h0, 1'b0, "rst_con");
        rd_chk(RXD, 32'h0, 1'b0, "rst_rxd");
        rd_chk(BAD, 32'h0, 1'b0, "unmapped");
        rd_chk(TXD, 32'h0, 1'b0, "txd_rd");
        wr_reg(CON, 32'hFFFF_FFFF, "con_wr_all");
        rd_chk(CON, 32'h2, 1'b0, "con_ie_only");
        wr_reg(CON, 32'h0, "con_clr");
        rd_chk(CON, 32'h0, 1'b0, "con_zero");

        txq.push_back(8'hA5);
        wr_reg(TXD, 32'h0000_00A5, "txd_a5");
        rd_chk(CON, 32'h04, 1'b0, "tx_busy_c0");
        repeat (158) tick();
        rd_chk(CON, 32'h04, 1'b0, "tx_busy_c159");
        rd_chk(CON, 32'h10, 1'b0, "tx_done_set");
        rd_chk(CON, 32'h00, 1'b0, "tx_done_clr");

        wr_reg(CON, 32'h2, "ie_on");
        send_rx(8'h3C, 1'b1);
        rd_chk(CON, 32'h0A, 1'b1, "rx_valid");
        rd_chk(RXD, 32'h3C, 1'b1, "rxd_3c");
        rd_chk(CON, 32'h02, 1'b0, "irq_clr");

`ifdef UART_RX_FIFO_EN
        for (int i = 1; i <= 5; i++) send_rx(8'(i), 1'b1);
        rd_chk(CON, 32'h32A, 1'b1, "fifo_full");
        for (int i = 1; i <= 4; i++) rd_chk(RXD, 32'(i), 1'b1, "fifo_pop");
        rd_chk(CON, 32'h02, 1'b0, "fifo_empty");
`else
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        rd_chk(CON, 32'h2A, 1'b1, "ovr_con");
        rd_chk(RXD, 32'h22, 1'b1, "ovr_rxd");
        rd_chk(CON, 32'h02, 1'b0, "ovr_clr");
`endif

        rx = 1'b0;
        repeat (4) tick();
        rx = 1'b1;
        repeat (30) tick();
        rd_chk(CON, 32'h02, 1'b0, "glitch");

        send_rx(8'h77, 1'b0);
        repeat (20) tick();
        rd_chk(CON, 32'h42, 1'b0, "frame_err");
        rd_chk(RXD, RXD_KEEP, 1'b0, "rxd_keep");
        rd_chk(CON, 32'h02, 1'b0, "ferr_clr");

        txq.push_back(8'h55);
        wr_reg(TXD, 32'h55, "txd_55");
        repeat (19) tick();
        wr_reg(TXD, 32'hAA, "txd_aa_busy");
        repeat (150) tick();
        rd_chk(CON, 32'h12, 1'b0, "tx55_done");
        rd_chk(CON, 32'h02, 1'b0, "tx55_clr");

        wr_reg(TXD, 32'h5A, "txd_5a");
        repeat (49) tick();
        reset = 1'b1;
        probe = 1'b1;
        repeat (2) tick();
        probe = 1'b0;
        reset = 1'b0;
        tick();
        rd_chk(CON, 32'h0, 1'b0, "rst_mid_con");
        repeat (120) tick();
        txq.push_back(8'hC3);
        wr_reg(TXD, 32'hC3, "txd_c3");
        repeat (165) tick();
        rd_chk(CON, 32'h10, 1'b0, "txc3_done");

        repeat (5) tick();
        fin = 1'b1;
        repeat (3) tick();
        if (!fin_done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL fin_check: got 0 want 1");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_mmio.md
Name: uart_mmio

Overview:
Memory-mapped UART peripheral that sits directly downstream of the pipeline's MEM-stage peripheral decode. It consumes the store/load strobes the CPU issues for addresses 0x4000_0018..0x4000_0020. It returns read data combinationally in the same cycle and raises the receive interrupt that drives the CPU's rx exception redirect. It contains independent 8N1 transmit and receive state machines sharing one baud divisor.

Parameters:
BAUD_DIV, 10417, clock cycles per UART bit (100 MHz / 9600); legal range 4..65535
ADDR_TXD, 32'h4000_0018, write-only transmit data register
ADDR_RXD, 32'h4000_001C, read-only receive data register
ADDR_CON, 32'h4000_0020, control/status register

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
sel  input  1  peripheral-space access qualifier from CPU decode
addr  input  32  byte address; only exact matches to ADDR_* respond
rd  input  1  read strobe, same cycle as addr
wr  input  1  write strobe, same cycle as addr
wdata  input  32  write data
rdata  output  32  combinational read data; 0 for unmatched address or rd low
rx  input  1  serial input, asynchronous
tx  output  1  serial output
rx_irq  output  1  receive interrupt, level

Behaviour:
- Reset (async, active-high): tx=1, rdata=0, rx_irq=0, both FSMs IDLE, all CON bits 0, RXD holding=0, counters 0. Reset mid-frame aborts the frame; tx goes high immediately.
- CON layout: bit1 rx_ie (R/W); bit2 tx_busy (RO); bit3 rx_valid (RO); bit4 tx_done (RO, sticky); bit5 rx_overrun (RO, sticky); bit6 frame_err (RO, sticky). Writing CON updates only bit1.
- Read side effects take effect on the clock edge with sel&rd: RXD read clears rx_valid; CON read clears tx_done, rx_overrun and frame_err. rdata shows pre-clear values.
- rx_irq = rx_valid & rx_ie, registered from state, no combinational path from inputs.
- TX FSM: IDLE, START, DATA, STOP.
  - sel&wr to ADDR_TXD in IDLE latches wdata[7:0] and enters START on the next edge; tx_busy=1 from that edge.
  - Each state lasts exactly BAUD_DIV cycles. DATA sends 8 bits LSB first, then STOP (tx=1), then IDLE.
  - On return to IDLE: tx_busy=0 and tx_done=1. Full frame = 10*BAUD_DIV cycles.
  - A write to TXD while busy is ignored, with no effect on the frame.
- RX FSM: IDLE, START, DATA, STOP. rx passes through a 2-flop synchronizer (2-cycle latency).
  - IDLE: a synchronized 0 enters START.
  - START: wait BAUD_DIV/2 (integer division), resample. If the sample is 1 (glitch), return to IDLE; otherwise enter DATA.
  - DATA: sample every BAUD_DIV cycles, 8 bits LSB first.
  - STOP: sample after BAUD_DIV cycles. If the stop bit is 1, load RXD and set rx_valid; if it is 0, set frame_err and discard the byte. Either way, return to IDLE.
- Overrun: a new byte completing while rx_valid=1 overwrites RXD and sets rx_overrun.
- Simultaneous events:
  - A byte completes in the same cycle as an RXD read: the set wins, RXD holds the new byte and rx_valid stays 1 (no overrun).
  - tx_done set coincides with a CON read: the set wins.
- Baud counters are 16-bit, one per FSM, reload at BAUD_DIV-1 and count down to 0.

Optional Feature:
UART_RX_FIFO_EN
- Defined: RXD becomes a 4-entry FIFO with 2-bit pointers and wrap-around.
  - rx_valid means "FIFO not empty"; an RXD read pops the entry.
  - A byte arriving when the FIFO is full is dropped and sets rx_overrun; FIFO contents are preserved.
  - Simultaneous push and pop while full: both proceed, no overrun.
  - CON bits 9:8 report occupancy minus one when non-empty.
- Not defined: single holding register as described in Behaviour. CON bits 9:8 read 0.

Test Plan:
- BAUD_DIV=16, write 0x000000A5 to TXD -> tx low for cycles 1..16 after the write edge, then bits 1,0,1,0,0,1,0,1, then high 16 cycles; tx_busy=1 for exactly 160 cycles, then tx_done=1; a CON read returns bit4=1, the next read returns bit4=0.
- Drive an 8N1 frame 0x3C on rx at 16 cycles/bit, rx_ie=1 -> rx_valid=1 and rx_irq=1 after the stop sample; RXD reads 0x0000003C; rx_irq=0 the cycle after the read edge.
- Two frames 0x11, 0x22 with no RXD read between -> RXD=0x22, CON bit5=1; with UART_RX_FIFO_EN: five frames 0x01..0x05 unread -> reads return 0x01..0x04, then rx_valid=0, overrun=1.
- Low pulse on rx of 4 cycles (< BAUD_DIV/2) -> RX returns to IDLE, no rx_valid, no frame_err; stop bit driven 0 -> frame_err=1, RXD unchanged.
- Write TXD 0x55 then 0xAA 20 cycles later -> only 0x55 is transmitted; reset asserted at cycle 50 of the frame -> tx=1 and CON=0 immediately, a new write after release transmits normally.
- Read of an unmatched address (0x4000_0024) or rd=0 -> rdata=0 with no state change; a CON write of 0xFFFFFFFF changes only rx_ie.
